// File: rtl/dispatcher_pkg.sv
// ============================================================================
// Module      : dispatcher_pkg
// Description : Shared constants and helpers for the 1-to-N dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dispatcher_pkg;

  localparam int DROP_CNT_W = 16;

  // Destination field width; a single bit is kept even for degenerate N.
  function automatic int dest_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo2_buf.sv
// ============================================================================
// Module      : fifo2_buf
// Description : Two-entry synchronous FIFO with asynchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo2_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [0:1];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign dout_o  = mem_q[rd_ptr_q];

  // Guard against overflow/underflow even if the caller misbehaves.
  assign w_push = push_i & ~full_o;
  assign w_pop  = pop_i & ~empty_o;

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (w_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dispatcher_dest_n.sv
// ============================================================================
// Module      : dispatcher_dest_n
// Description : Buffered 1-to-N stream dispatcher routed by a data-word field.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dispatcher_dest_n
  import dispatcher_pkg::*;
#(
  parameter int DWIDTH   = 20,
  parameter int N        = 2,
  parameter int DEST_LSB = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  input  logic [DWIDTH-1:0]     in_data_i,
  output logic                  in_ready_o,
  output logic                  out_valid_o [N-1:0],
  output logic [DWIDTH-1:0]     out_data_o  [N-1:0],
  input  logic                  out_ready_i [N-1:0],
  output logic                  drop_pulse_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  localparam int DESTW = dest_width(N);

  logic [DWIDTH-1:0]     w_head;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic [DESTW-1:0]      w_dest;
  logic                  w_dest_ok;
  logic                  w_sel_ready;
  logic                  w_drop;
  logic [DROP_CNT_W-1:0] drop_cnt_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  fifo2_buf #(
    .WIDTH (DWIDTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .din_i   (in_data_i),
    .full_o  (w_full),
    .pop_i   (w_pop),
    .dout_o  (w_head),
    .empty_o (w_empty)
  );

  // Readiness depends on buffer occupancy only, never on any out_ready.
  assign in_ready_o = ~w_full & ~rst;
  assign w_push     = in_valid_i & in_ready_o;

  assign w_dest = w_head[DEST_LSB +: DESTW];

  always_comb begin
    w_dest_ok   = 1'b0;
    w_sel_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (w_dest == DESTW'(k)) begin
        w_dest_ok   = 1'b1;
        w_sel_ready = out_ready_i[k];
      end
    end
  end

  assign w_drop       = ~w_empty & ~w_dest_ok;
  assign w_pop        = ~w_empty & (w_drop | w_sel_ready);
  assign drop_pulse_o = w_drop;

  generate
    for (genvar k = 0; k < N; k++) begin : g_out
      assign out_valid_o[k] = ~w_empty & (w_dest == DESTW'(k));
      assign out_data_o[k]  = w_empty ? '0 : w_head;
    end
  endgenerate

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (w_drop && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt_o = drop_cnt_q;

endmodule

`default_nettype wire
